// File: rtl/rpn_calc_pkg.sv
// ============================================================================
//  Module      : rpn_calc_pkg
//  Description : Shared types and defaults for the RPN calculation engine.
//                Operator codes as carried in the low 3 bits of tok_value,
//                FSM state encoding, and default datapath/stack sizes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rpn_calc_pkg;

  // Operator codes carried in tok_value[2:0] on an operator token.
  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MUL = 3'd3,
    OP_DIV = 3'd4,
    OP_MOD = 3'd5
  } op_e;

  // Engine FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    WB   = 2'd3
  } state_e;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_STACK_DEPTH = 4;

endpackage : rpn_calc_pkg

`default_nettype wire

// File: rtl/calc_divider.sv
// ============================================================================
//  Module      : calc_divider
//  Description : Restoring shift-subtract divider, one quotient bit per cycle.
//                The start cycle already performs the first iteration on the
//                live operands, so done_o pulses DATA_W-1 cycles after start.
//  Ports       : clk, rst (async, active-high)
//                start_i      - one-cycle strobe, samples dividend/divisor
//                dividend_i   - numerator
//                divisor_i    - denominator (caller guarantees non-zero)
//                done_o       - one-cycle pulse, results valid
//                quotient_o   - dividend / divisor
//                remainder_o  - dividend % divisor
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_divider #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              run_q, done_q;

  logic [DATA_W-1:0] w_rem_in, w_quo_in, w_dvs;
  logic [DATA_W:0]   w_sh, w_diff;
  logic [DATA_W-1:0] w_rem_nx, w_quo_nx;

  // On the start cycle the iteration runs on the fresh operands, not on the
  // stale registers, which saves one cycle of latency.
  always_comb begin
    w_rem_in = start_i ? '0         : rem_q;
    w_quo_in = start_i ? dividend_i : quo_q;
    w_dvs    = start_i ? divisor_i  : dvs_q;
    w_sh     = {w_rem_in, w_quo_in[DATA_W-1]};
    w_diff   = w_sh - {1'b0, w_dvs};
    // Remainder stays below the divisor, so the shifted value fits in
    // DATA_W bits whenever the trial subtraction goes negative.
    w_rem_nx = w_diff[DATA_W] ? w_sh[DATA_W-1:0] : w_diff[DATA_W-1:0];
    w_quo_nx = {w_quo_in[DATA_W-2:0], ~w_diff[DATA_W]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q <= w_rem_nx;
        quo_q <= w_quo_nx;
        dvs_q <= divisor_i;
        cnt_q <= CNT_W'(1);
        run_q <= 1'b1;
      end else if (run_q) begin
        rem_q <= w_rem_nx;
        quo_q <= w_quo_nx;
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule : calc_divider

`default_nettype wire

// File: rtl/rpn_calc_engine.sv
// ============================================================================
//  Module      : rpn_calc_engine
//  Description : Reverse-Polish calculation engine with an operand stack.
//                Number tokens load the entry register, enter pushes it,
//                operator tokens pop two operands (a = below top, b = top)
//                and push the result. DIV/MOD use the multi-cycle divider.
//  Config      : RPN_CALC_SATURATE_EN - when defined, ADD/MUL overflow
//                saturates to all-ones and SUB with a<b clamps to 0.
//  Ports       : clk, rst (async, active-high)
//                tok_valid/tok_is_op/tok_value - token input
//                enter   - push entry register
//                busy    - executing, inputs ignored
//                a, b    - stack entry below top / stack top
//                op      - last accepted operator
//                result, sign, overflow - last computed result
//                err     - sticky error, cleared by next accepted token
//                depth   - stack occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rpn_calc_engine
  import rpn_calc_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               tok_valid,
  input  logic                               tok_is_op,
  input  logic [DATA_W-1:0]                  tok_value,
  input  logic                               enter,
  output logic                               busy,
  output logic [DATA_W-1:0]                  a,
  output logic [DATA_W-1:0]                  b,
  output logic [2:0]                         op,
  output logic [DATA_W-1:0]                  result,
  output logic                               sign,
  output logic                               overflow,
  output logic                               err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_DIV  = DIV;
  localparam logic [1:0] S_WB   = WB;

  logic [DATA_W-1:0]  stack_q [STACK_DEPTH];
  logic [DATA_W-1:0]  stack_d [STACK_DEPTH];
  logic [DATA_W-1:0]  entry_q, entry_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [2:0]         op_q, op_d;
  logic               sign_q, sign_d, ovf_q, ovf_d, err_q, err_d, busy_q, busy_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [1:0]         state_q, state_d;

  logic               w_div_start, w_div_done;
  logic [DATA_W-1:0]  w_quot, w_rem;

  logic [2:0]          w_tok_op;
  logic [DATA_W:0]     w_sum;
  logic [2*DATA_W-1:0] w_prod;
  logic                w_a_lt_b;
  logic [DATA_W-1:0]   w_absdiff;

  assign w_tok_op  = tok_value[2:0];
  // a_q/b_q mirror the two top stack entries, so they are the live operands.
  assign w_sum     = {1'b0, a_q} + {1'b0, b_q};
  assign w_prod    = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
  assign w_a_lt_b  = (a_q < b_q);
  assign w_absdiff = w_a_lt_b ? (b_q - a_q) : (a_q - b_q);

  calc_divider #(
    .DATA_W (DATA_W)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (w_div_start),
    .dividend_i  (a_q),
    .divisor_i   (b_q),
    .done_o      (w_div_done),
    .quotient_o  (w_quot),
    .remainder_o (w_rem)
  );

  always_comb begin
    stack_d     = stack_q;
    depth_d     = depth_q;
    entry_d     = entry_q;
    op_d        = op_q;
    result_d    = result_q;
    sign_d      = sign_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    busy_d      = busy_q;
    state_d     = state_q;
    w_div_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A token in the same cycle as enter takes priority.
        if (tok_valid) begin
          err_d = 1'b0;
          if (!tok_is_op) begin
            entry_d = tok_value;
          end else begin
            case (w_tok_op)
              OP_NOP: ;
              OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: begin
                if (depth_q >= DEPTH_W'(2)) begin
                  op_d    = w_tok_op;
                  busy_d  = 1'b1;
                  state_d = S_EXEC;
                end else begin
                  err_d = 1'b1;
                end
              end
              default: err_d = 1'b1;
            endcase
          end
        end else if (enter) begin
          if (depth_q < DEPTH_W'(STACK_DEPTH)) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
              if (i == int'(depth_q)) stack_d[i] = entry_q;
            end
            depth_d = depth_q + DEPTH_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_EXEC: begin
        state_d = S_WB;
        sign_d  = 1'b0;
        ovf_d   = 1'b0;
        case (op_q)
          OP_ADD: begin
            ovf_d    = w_sum[DATA_W];
            result_d = w_sum[DATA_W-1:0];
`ifdef RPN_CALC_SATURATE_EN
            if (w_sum[DATA_W]) result_d = '1;
`endif
          end
          OP_SUB: begin
`ifdef RPN_CALC_SATURATE_EN
            result_d = w_a_lt_b ? '0 : w_absdiff;
`else
            result_d = w_absdiff;
            sign_d   = w_a_lt_b;
`endif
          end
          OP_MUL: begin
            ovf_d    = |w_prod[2*DATA_W-1:DATA_W];
            result_d = w_prod[DATA_W-1:0];
`ifdef RPN_CALC_SATURATE_EN
            if (|w_prod[2*DATA_W-1:DATA_W]) result_d = '1;
`endif
          end
          OP_DIV, OP_MOD: begin
            if (b_q == '0) begin
              // Divide by zero aborts without touching the stack.
              err_d    = 1'b1;
              result_d = '1;
              ovf_d    = 1'b1;
              busy_d   = 1'b0;
              state_d  = S_IDLE;
            end else begin
              w_div_start = 1'b1;
              state_d     = S_DIV;
            end
          end
          default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        endcase
      end

      S_DIV: begin
        if (w_div_done) begin
          result_d = (op_q == OP_MOD) ? w_rem : w_quot;
          ovf_d    = 1'b0;
          sign_d   = 1'b0;
          state_d  = S_WB;
        end
      end

      S_WB: begin
        // Pop a and b, push result: the result overwrites a's slot.
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (i == int'(depth_q) - 2) stack_d[i] = result_q;
        end
        depth_d = depth_q - DEPTH_W'(1);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // a/b are registered views of the next stack state.
    a_d = '0;
    b_d = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (i == int'(depth_d) - 1) b_d = stack_d[i];
      if (i == int'(depth_d) - 2) a_d = stack_d[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      depth_q  <= '0;
      entry_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_NOP;
      result_q <= '0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      state_q  <= S_IDLE;
    end else begin
      stack_q  <= stack_d;
      depth_q  <= depth_d;
      entry_q  <= entry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      state_q  <= state_d;
    end
  end

  assign busy     = busy_q;
  assign a        = a_q;
  assign b        = b_q;
  assign op       = op_q;
  assign result   = result_q;
  assign sign     = sign_q;
  assign overflow = ovf_q;
  assign err      = err_q;
  assign depth    = depth_q;

endmodule : rpn_calc_engine

`default_nettype wire

// File: tb/tb_rpn_calc_engine.sv
// ============================================================================
//  Module      : tb_rpn_calc_engine
//  Description : Self-checking bench for rpn_calc_engine (DATA_W=8,
//                STACK_DEPTH=4). Directed scenarios plus a randomized token
//                stream checked against a queue-based RPN model.
//  Config      : honours RPN_CALC_SATURATE_EN for expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rpn_calc_engine;

  localparam int DATA_W      = 8;
  localparam int STACK_DEPTH = 4;
  localparam int MASK        = (1 << DATA_W) - 1;
  localparam int DW          = $clog2(STACK_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tok_valid = 1'b0;
  logic              tok_is_op = 1'b0;
  logic [DATA_W-1:0] tok_value = '0;
  logic              enter = 1'b0;
  logic              busy;
  logic [DATA_W-1:0] a, b, result;
  logic [2:0]        op;
  logic              sign, overflow, err;
  logic [DW-1:0]     depth;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_stack[$];
  int m_entry, m_err, m_op, m_res, m_sign, m_ovf;

  rpn_calc_engine #(
    .DATA_W      (DATA_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tok_valid (tok_valid),
    .tok_is_op (tok_is_op),
    .tok_value (tok_value),
    .enter     (enter),
    .busy      (busy),
    .a         (a),
    .b         (b),
    .op        (op),
    .result    (result),
    .sign      (sign),
    .overflow  (overflow),
    .err       (err),
    .depth     (depth)
  );

  always #5 clk = ~clk;

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic isop, input int val, input logic en);
    @(negedge clk);
    tok_valid = v; tok_is_op = isop; tok_value = DATA_W'(val); enter = en;
    @(negedge clk);
    tok_valid = 1'b0; tok_is_op = 1'b0; tok_value = '0; enter = 1'b0;
  endtask

  task automatic push(input int val);
    drive(1'b1, 1'b0, val, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b1);
  endtask

  // Cycles from the op-token capture edge until busy drops (capped at 50).
  task automatic wait_idle(output int lat);
    lat = 0;
    while (busy === 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tok_valid = 1'b0; tok_is_op = 1'b0; tok_value = '0; enter = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_stack.delete();
    m_entry = 0; m_err = 0; m_op = 0; m_res = 0; m_sign = 0; m_ovf = 0;
  endtask

  // ---------------- reference model ----------------
  task automatic model_op(input int code, output int lat);
    int ma, mb, sz;
    lat   = 0;
    m_err = 0;
    sz    = m_stack.size();
    if (code == 0) return;
    if (sz < 2) begin m_err = 1; return; end
    m_op = code;
    ma = m_stack[sz-2];
    mb = m_stack[sz-1];
    m_sign = 0; m_ovf = 0; lat = 2;
    case (code)
      1: begin
        m_res = ma + mb; m_ovf = (m_res > MASK);
`ifdef RPN_CALC_SATURATE_EN
        if (m_ovf) m_res = MASK;
`endif
        m_res &= MASK;
      end
      2: begin
`ifdef RPN_CALC_SATURATE_EN
        m_res = (ma < mb) ? 0 : ma - mb;
`else
        m_res = (ma < mb) ? mb - ma : ma - mb;
        m_sign = (ma < mb);
`endif
      end
      3: begin
        m_res = ma * mb; m_ovf = (m_res > MASK);
`ifdef RPN_CALC_SATURATE_EN
        if (m_ovf) m_res = MASK;
`endif
        m_res &= MASK;
      end
      default: begin
        if (mb == 0) begin
          m_err = 1; m_res = MASK; m_ovf = 1; lat = 1;
          return;
        end
        m_res = (code == 4) ? ma / mb : ma % mb;
        lat = DATA_W + 2;
      end
    endcase
    void'(m_stack.pop_back());
    void'(m_stack.pop_back());
    m_stack.push_back(m_res);
  endtask

  task automatic model_enter();
    if (m_stack.size() < STACK_DEPTH) m_stack.push_back(m_entry);
    else m_err = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({a, b, result} !== '0 || op !== 3'd0 || depth !== '0) begin
      n_fail++;
      $display("FAIL reset_data: a=%0d b=%0d result=%0d op=%0d depth=%0d, required all 0", a, b, result, op, depth);
    end
    n_checks++;
    if ({busy, sign, overflow, err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy/sign/ovf/err=%b, required 0000", {busy, sign, overflow, err});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    do_reset();
    push(12); push(30);
    drive(1'b1, 1'b1, 1, 1'b0);
    wait_idle(lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d, required 2", lat); end
    n_checks++;
    if (result !== 8'd42 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL add_result: result=%0d ovf=%b, required 42/0", result, overflow);
    end
    n_checks++;
    if (depth !== 3'd1 || b !== 8'd42 || a !== 8'd0 || op !== 3'd1) begin
      n_fail++; $display("FAIL add_stack: depth=%0d b=%0d a=%0d op=%0d, required 1/42/0/1", depth, b, a, op);
    end
  endtask

  task automatic test_sub();
    int lat;
    logic [DATA_W-1:0] exp_r;
    logic exp_s;
`ifdef RPN_CALC_SATURATE_EN
    exp_r = 8'd0; exp_s = 1'b0;
`else
    exp_r = 8'd4; exp_s = 1'b1;
`endif
    do_reset();
    push(5); push(9);
    drive(1'b1, 1'b1, 2, 1'b0);
    wait_idle(lat);
    n_checks++;
    if (result !== exp_r || sign !== exp_s || overflow !== 1'b0) begin
      n_fail++; $display("FAIL sub_result: result=%0d sign=%b ovf=%b, required %0d/%b/0", result, sign, overflow, exp_r, exp_s);
    end
  endtask

  task automatic test_divmod();
    int lat;
    do_reset();
    push(200); push(7);
    drive(1'b1, 1'b1, 4, 1'b0);
    wait_idle(lat);
    n_checks++;
    if (lat !== DATA_W + 2) begin n_fail++; $display("FAIL div_latency: got %0d, required %0d", lat, DATA_W + 2); end
    n_checks++;
    if (result !== 8'd28 || depth !== 3'd1 || b !== 8'd28) begin
      n_fail++; $display("FAIL div_result: result=%0d depth=%0d b=%0d, required 28/1/28", result, depth, b);
    end
    push(200); push(7);
    drive(1'b1, 1'b1, 5, 1'b0);
    wait_idle(lat);
    n_checks++;
    if (result !== 8'd4 || depth !== 3'd2 || b !== 8'd4 || a !== 8'd28 || lat !== DATA_W + 2) begin
      n_fail++; $display("FAIL mod_result: result=%0d depth=%0d b=%0d a=%0d lat=%0d, required 4/2/4/28/%0d", result, depth, b, a, lat, DATA_W + 2);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    do_reset();
    push(9); push(0);
    drive(1'b1, 1'b1, 4, 1'b0);
    wait_idle(lat);
    n_checks++;
    if (err !== 1'b1 || result !== 8'd255 || overflow !== 1'b1 || depth !== 3'd2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL div_zero: err=%b result=%0d ovf=%b depth=%0d busy=%b, required 1/255/1/2/0", err, result, overflow, depth, busy);
    end
    drive(1'b1, 1'b0, 3, 1'b0);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL div_zero_clear: err=%b, required 0", err); end
  endtask

  task automatic test_stack_limits();
    int lat;
    do_reset();
    for (int i = 1; i <= 4; i++) push(i);
    n_checks++;
    if (depth !== 3'd4 || err !== 1'b0 || b !== 8'd4 || a !== 8'd3) begin
      n_fail++; $display("FAIL stack_full: depth=%0d err=%b b=%0d a=%0d, required 4/0/4/3", depth, err, b, a);
    end
    drive(1'b0, 1'b0, 0, 1'b1);
    n_checks++;
    if (depth !== 3'd4 || err !== 1'b1 || b !== 8'd4) begin
      n_fail++; $display("FAIL stack_overflow: depth=%0d err=%b b=%0d, required 4/1/4", depth, err, b);
    end
    do_reset();
    push(1);
    drive(1'b1, 1'b1, 3, 1'b0);
    wait_idle(lat);
    n_checks++;
    if (err !== 1'b1 || depth !== 3'd1 || op !== 3'd0 || lat !== 0) begin
      n_fail++; $display("FAIL stack_underflow: err=%b depth=%0d op=%0d lat=%0d, required 1/1/0/0", err, depth, op, lat);
    end
  endtask

  task automatic test_mul_overflow();
    int lat;
    logic [DATA_W-1:0] exp_r;
`ifdef RPN_CALC_SATURATE_EN
    exp_r = 8'd255;
`else
    exp_r = 8'd0;
`endif
    do_reset();
    push(16); push(16);
    drive(1'b1, 1'b1, 3, 1'b0);
    wait_idle(lat);
    n_checks++;
    if (result !== exp_r || overflow !== 1'b1 || lat !== 2) begin
      n_fail++; $display("FAIL mul_overflow: result=%0d ovf=%b lat=%0d, required %0d/1/2", result, overflow, lat, exp_r);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    do_reset();
    push(200); push(7);
    drive(1'b1, 1'b1, 4, 1'b0);
    // Tokens and enter while busy must be dropped.
    drive(1'b1, 1'b0, 99, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b1);
    drive(1'b1, 1'b1, 1, 1'b0);
    wait_idle(lat);
    n_checks++;
    if (result !== 8'd28 || depth !== 3'd1 || op !== 3'd4) begin
      n_fail++; $display("FAIL busy_ignore: result=%0d depth=%0d op=%0d, required 28/1/4", result, depth, op);
    end
    drive(1'b0, 1'b0, 0, 1'b1);
    n_checks++;
    if (b !== 8'd7 || depth !== 3'd2) begin
      n_fail++; $display("FAIL busy_entry: b=%0d depth=%0d, required 7/2", b, depth);
    end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    do_reset();
    push(200); push(7);
    drive(1'b1, 1'b1, 4, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || {a, b, result} !== '0 || depth !== '0 || op !== 3'd0 || {sign, overflow, err} !== 3'b0) begin
      n_fail++; $display("FAIL reset_mid_div: busy=%b a=%0d b=%0d result=%0d depth=%0d op=%0d, required all 0", busy, a, b, result, depth, op);
    end
    @(negedge clk);
    rst = 1'b0;
    push(1); push(2);
    drive(1'b1, 1'b1, 1, 1'b0);
    wait_idle(lat);
    n_checks++;
    if (result !== 8'd3 || depth !== 3'd1) begin
      n_fail++; $display("FAIL reset_recover: result=%0d depth=%0d, required 3/1", result, depth);
    end
  endtask

  task automatic test_random();
    int lat, exp_lat, r, v, code;
    int ea, eb, sz;
    do_reset();
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, MASK);
      code = $urandom_range(0, 5);
      exp_lat = 0;
      if (r <= 3) begin
        drive(1'b1, 1'b0, v, 1'b0);
        m_err = 0; m_entry = v;
      end else if (r <= 6) begin
        drive(1'b0, 1'b0, 0, 1'b1);
        model_enter();
      end else if (r <= 8) begin
        drive(1'b1, 1'b1, code, 1'b0);
        model_op(code, exp_lat);
      end else begin
        drive(1'b1, 1'b0, v, 1'b1);
        m_err = 0; m_entry = v;
      end
      wait_idle(lat);
      sz = m_stack.size();
      eb = (sz >= 1) ? m_stack[sz-1] : 0;
      ea = (sz >= 2) ? m_stack[sz-2] : 0;
      n_checks++;
      if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d, required %0d", it, lat, exp_lat); end
      n_checks++;
      if (int'(depth) !== sz) begin n_fail++; $display("FAIL rnd_depth[%0d]: got %0d, required %0d", it, depth, sz); end
      n_checks++;
      if (int'(a) !== ea || int'(b) !== eb) begin
        n_fail++; $display("FAIL rnd_ab[%0d]: a=%0d b=%0d, required %0d/%0d", it, a, b, ea, eb);
      end
      n_checks++;
      if (int'(err) !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b, required %0d", it, err, m_err); end
      n_checks++;
      if (int'(op) !== m_op) begin n_fail++; $display("FAIL rnd_op[%0d]: got %0d, required %0d", it, op, m_op); end
      n_checks++;
      if (int'(result) !== m_res || int'(sign) !== m_sign || int'(overflow) !== m_ovf) begin
        n_fail++; $display("FAIL rnd_result[%0d]: result=%0d sign=%b ovf=%b, required %0d/%0d/%0d", it, result, sign, overflow, m_res, m_sign, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_divmod();
    test_div_zero();
    test_stack_limits();
    test_mul_overflow();
    test_busy_ignore();
    test_reset_mid_div();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rpn_calc_engine

`default_nettype wire
